// File: rtl/csr_sysop_exec.sv
// Machine-mode CSR / system-op executor: CSR read-modify-write, ECALL/EBREAK trap entry and MRET,
// one request at a time, with a registered response and fetch redirect.
module csr_sysop_exec #(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_MTVEC = XLEN'(64'h0000_0000_8000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      e_cause,
    input  logic [XLEN-1:0] e_tval,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] rd_data,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);
    localparam logic [4:0] SysopEcall  = 5'd1;
    localparam logic [4:0] SysopEbreak = 5'd2;
    localparam logic [4:0] SysopRet    = 5'd3;
    localparam logic [4:0] SysopCsrW   = 5'd4;
    localparam logic [4:0] SysopCsrS   = 5'd5;
    localparam logic [4:0] SysopCsrC   = 5'd6;

    typedef enum logic [2:0] {StIdle, StCsrRd, StCsrWr, StTrap, StRet, StResp} state_e;

    state_e          state_q;
    logic [4:0]      cause_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] pc_q, rs1_q, old_q;
    logic [XLEN-1:0] trap_cause_q, trap_val_q;
    logic            mie_q, mpie_q;
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [XLEN-1:0] csr_rdata, csr_wdata;
    logic            unused_tval;

    assign unused_tval = ^e_tval[XLEN-1:12];

    function automatic logic csr_mapped(input logic [11:0] a);
        return (a == 12'h300) || (a == 12'h305) || (a == 12'h340) || (a == 12'h341) ||
               (a == 12'h342) || (a == 12'h343);
    endfunction

    always_comb begin
        csr_rdata = '0;
        case (addr_q)
            12'h300: begin
                csr_rdata[3] = mie_q;
                csr_rdata[7] = mpie_q;
            end
            12'h305: csr_rdata = mtvec_q;
            12'h340: csr_rdata = mscratch_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h343: csr_rdata = mtval_q;
            default: csr_rdata = '0;
        endcase
    end

    always_comb begin
        case (cause_q)
            SysopCsrS: csr_wdata = old_q | rs1_q;
            SysopCsrC: csr_wdata = old_q & ~rs1_q;
            default:   csr_wdata = rs1_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cause_q      <= '0;
            addr_q       <= '0;
            pc_q         <= '0;
            rs1_q        <= '0;
            old_q        <= '0;
            trap_cause_q <= '0;
            trap_val_q   <= '0;
            mie_q        <= 1'b0;
            mpie_q       <= 1'b0;
            mtvec_q      <= RESET_MTVEC;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            rd_data      <= '0;
            redirect     <= 1'b0;
            redirect_pc  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid && !flush) begin
                        cause_q   <= e_cause;
                        addr_q    <= e_tval[11:0];
                        pc_q      <= pc;
                        rs1_q     <= rs1_data;
                        req_ready <= 1'b0;
                        case (e_cause)
                            SysopCsrW, SysopCsrS, SysopCsrC: begin
                                if (csr_mapped(e_tval[11:0])) begin
                                    state_q <= StCsrRd;
                                end else begin
                                    state_q      <= StTrap;
                                    trap_cause_q <= XLEN'(2);
                                    trap_val_q   <= XLEN'(e_tval[11:0]);
                                end
                            end
                            SysopEcall: begin
                                state_q      <= StTrap;
                                trap_cause_q <= XLEN'(11);
                                trap_val_q   <= '0;
                            end
                            SysopEbreak: begin
                                state_q      <= StTrap;
                                trap_cause_q <= XLEN'(3);
                                trap_val_q   <= pc;
                            end
                            SysopRet: state_q <= StRet;
                            5'd0: begin
                                state_q    <= StResp;
                                resp_valid <= 1'b1;
                            end
                            default: begin
                                state_q      <= StTrap;
                                trap_cause_q <= XLEN'(2);
                                trap_val_q   <= '0;
                            end
                        endcase
                    end
                end
                StCsrRd: begin
                    if (flush) begin
                        state_q   <= StIdle;
                        req_ready <= 1'b1;
                    end else begin
                        old_q   <= csr_rdata;
                        state_q <= StCsrWr;
                    end
                end
                StCsrWr: begin
                    // The write commits even when flushed; only the response is dropped.
                    case (addr_q)
                        12'h300: begin
                            mie_q  <= csr_wdata[3];
                            mpie_q <= csr_wdata[7];
                        end
                        12'h305: mtvec_q    <= csr_wdata;
                        12'h340: mscratch_q <= csr_wdata;
                        12'h341: mepc_q     <= {csr_wdata[XLEN-1:2], 2'b00};
                        12'h342: mcause_q   <= csr_wdata;
                        12'h343: mtval_q    <= csr_wdata;
                        default: ;
                    endcase
                    if (flush) begin
                        state_q   <= StIdle;
                        req_ready <= 1'b1;
                    end else begin
                        state_q    <= StResp;
                        resp_valid <= 1'b1;
                        rd_data    <= old_q;
                    end
                end
                StTrap: begin
                    if (flush) begin
                        state_q   <= StIdle;
                        req_ready <= 1'b1;
                    end else begin
                        mepc_q      <= {pc_q[XLEN-1:2], 2'b00};
                        mcause_q    <= trap_cause_q;
                        mtval_q     <= trap_val_q;
                        mpie_q      <= mie_q;
                        mie_q       <= 1'b0;
                        state_q     <= StResp;
                        resp_valid  <= 1'b1;
                        redirect    <= 1'b1;
                        redirect_pc <= {mtvec_q[XLEN-1:2], 2'b00};
                    end
                end
                StRet: begin
                    if (flush) begin
                        state_q   <= StIdle;
                        req_ready <= 1'b1;
                    end else begin
                        mie_q       <= mpie_q;
                        mpie_q      <= 1'b1;
                        state_q     <= StResp;
                        resp_valid  <= 1'b1;
                        redirect    <= 1'b1;
                        redirect_pc <= mepc_q;
                    end
                end
                StResp: begin
                    if (flush || resp_ready) begin
                        state_q     <= StIdle;
                        req_ready   <= 1'b1;
                        resp_valid  <= 1'b0;
                        rd_data     <= '0;
                        redirect    <= 1'b0;
                        redirect_pc <= '0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_sysop_exec.sv
// Directed bench for csr_sysop_exec: CSR ops, traps, MRET, backpressure and flush.
module tb_csr_sysop_exec;
    localparam logic [4:0] ECALL = 5'd1, EBREAK = 5'd2, RET = 5'd3;
    localparam logic [4:0] CSRW = 5'd4, CSRS = 5'd5, CSRC = 5'd6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, flush, resp_valid, resp_ready, redirect;
    logic [4:0]  e_cause;
    logic [63:0] e_tval, pc, rs1_data, rd_data, redirect_pc;

    int total = 0;
    int bad   = 0;

    csr_sysop_exec #(.XLEN(64), .RESET_MTVEC(64'h0000_0000_8000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .e_cause(e_cause), .e_tval(e_tval), .pc(pc), .rs1_data(rs1_data), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .rd_data(rd_data),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request with resp_ready high; check latency and response fields.
    task automatic req(input logic [4:0] c, input logic [63:0] tv, input logic [63:0] p,
                       input logic [63:0] r, input int exp_lat, input logic [63:0] exp_rd,
                       input logic exp_redir, input logic [63:0] exp_rpc, input string tag);
        int lat;
        chk({tag, ".ready"}, 64'(req_ready), 64'd1);
        e_cause = c; e_tval = tv; pc = p; rs1_data = r;
        req_valid = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".rd"}, rd_data, exp_rd);
        chk({tag, ".redir"}, 64'(redirect), 64'(exp_redir));
        chk({tag, ".rpc"}, redirect_pc, exp_rpc);
        @(posedge clk); #1;
        chk({tag, ".done"}, 64'(resp_valid), 64'd0);
    endtask

    // Read a CSR by setting no bits.
    task automatic rd_csr(input logic [11:0] a, input logic [63:0] exp, input string tag);
        req(CSRS, 64'(a), 64'h0, 64'h0, 3, exp, 1'b0, 64'h0, tag);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
        e_cause = '0; e_tval = '0; pc = '0; rs1_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst.req_ready", 64'(req_ready), 64'd1);
        chk("rst.resp_valid", 64'(resp_valid), 64'd0);
        chk("rst.rd_data", rd_data, 64'h0);
        chk("rst.redirect", 64'(redirect), 64'd0);
        rd_csr(12'h305, 64'h8000_0000, "rst.mtvec");

        req(CSRW, 64'h340, 64'h0, 64'hA5, 3, 64'h0, 1'b0, 64'h0, "mscr.w");
        req(CSRS, 64'h340, 64'h0, 64'h5A, 3, 64'hA5, 1'b0, 64'h0, "mscr.s");
        rd_csr(12'h340, 64'hFF, "mscr.rb");

        // Only MIE/MPIE survive an all-ones write.
        req(CSRW, 64'h300, 64'h0, '1, 3, 64'h0, 1'b0, 64'h0, "mst.w");
        req(CSRC, 64'h300, 64'h0, 64'h80, 3, 64'h88, 1'b0, 64'h0, "mst.c");
        rd_csr(12'h300, 64'h08, "mst.rb");

        req(ECALL, 64'h0, 64'h8000_1004, 64'h0, 2, 64'h0, 1'b1, 64'h8000_0000, "ecall");
        rd_csr(12'h341, 64'h8000_1004, "ecall.mepc");
        rd_csr(12'h342, 64'd11, "ecall.mcause");
        rd_csr(12'h343, 64'h0, "ecall.mtval");
        rd_csr(12'h300, 64'h80, "ecall.mstatus");

        req(RET, 64'h0, 64'h0, 64'h0, 2, 64'h0, 1'b1, 64'h8000_1004, "mret");
        rd_csr(12'h300, 64'h88, "mret.mstatus");

        req(CSRC, 64'h7C0, 64'h8000_2002, 64'hFF, 2, 64'h0, 1'b1, 64'h8000_0000, "illeg");
        rd_csr(12'h342, 64'd2, "illeg.mcause");
        rd_csr(12'h343, 64'h7C0, "illeg.mtval");
        rd_csr(12'h341, 64'h8000_2000, "illeg.mepc");
        rd_csr(12'h340, 64'hFF, "illeg.mscratch");
        rd_csr(12'h300, 64'h80, "illeg.mstatus");

        req(EBREAK, 64'h0, 64'h1234_5678, 64'h0, 2, 64'h0, 1'b1, 64'h8000_0000, "ebrk");
        rd_csr(12'h342, 64'd3, "ebrk.mcause");
        rd_csr(12'h343, 64'h1234_5678, "ebrk.mtval");

        req(5'd0, 64'h340, 64'h0, 64'h0, 1, 64'h0, 1'b0, 64'h0, "nop");
        req(5'd17, 64'h0, 64'h0, 64'h0, 2, 64'h0, 1'b1, 64'h8000_0000, "badcode");
        rd_csr(12'h342, 64'd2, "badcode.mcause");

        // mtvec low bits are masked off the trap target.
        req(CSRW, 64'h305, 64'h0, 64'h9000_0003, 3, 64'h8000_0000, 1'b0, 64'h0, "mtvec.w");
        req(ECALL, 64'h0, 64'h40, 64'h0, 2, 64'h0, 1'b1, 64'h9000_0000, "mtvec.trap");

        // Backpressure: response must hold while resp_ready is low.
        e_cause = CSRS; e_tval = 64'h340; rs1_data = 64'h0;
        req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", 64'(resp_valid), 64'd1);
            chk("bp.rd", rd_data, 64'hFF);
            chk("bp.redir", 64'(redirect), 64'd0);
            chk("bp.ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.release.valid", 64'(resp_valid), 64'd0);
        chk("bp.release.ready", 64'(req_ready), 64'd1);

        // Flush while in CSR_RD: no write, idle next cycle.
        e_cause = CSRW; e_tval = 64'h340; rs1_data = 64'h11;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush.ready", 64'(req_ready), 64'd1);
        chk("flush.valid", 64'(resp_valid), 64'd0);
        rd_csr(12'h340, 64'hFF, "flush.mscratch");

        // Flush in IDLE blocks accept.
        e_cause = CSRW; e_tval = 64'h340; rs1_data = 64'h22;
        req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        chk("flush.idle.ready", 64'(req_ready), 64'd1);
        rd_csr(12'h340, 64'hFF, "flush.idle.mscratch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/csr_sysop_exec.md
Name: csr_sysop_exec

Overview:
- Consumer end of the execute-stage system-op interface: takes the 5-bit sysop cause code and 64-bit tval, then carries out the operation.
- Implements the machine-mode CSR subset: CSR read/write/set/clear, ECALL/EBREAK trap entry, and MRET return.
- Sits after execute. Produces rd writeback data and a PC redirect for fetch.
- Handles one request at a time under a valid/ready handshake.

Parameters:
- XLEN, 64, data and address width.
- RESET_MTVEC, 64'h0000_0000_8000_0000, reset value of mtvec.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- e_cause  input  5  csr.vh SYSOP_* code (ECALL, EBREAK, RET, CSR_W, CSR_S, CSR_C); 0 = no op
- e_tval  input  XLEN  CSR address in [11:0] for CSR ops
- pc  input  XLEN  PC of the system instruction
- rs1_data  input  XLEN  operand for CSR ops
- flush  input  1  abort any in-flight request
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- rd_data  output  XLEN  old CSR value (CSR ops), else 0
- redirect  output  1  with resp_valid: fetch must jump
- redirect_pc  output  XLEN  jump target

Behaviour:
- Reset (rst_n=0 at posedge):
  - State = IDLE; all outputs 0 except req_ready=1.
  - mstatus=0, mepc=0, mcause=0, mtval=0, mscratch=0, mtvec=RESET_MTVEC.
- Reset mid-operation discards the request; no CSR is written.
- CSR map:
  - mstatus 0x300: only MIE[3] and MPIE[7] writable; other bits read 0.
  - mtvec 0x305.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] forced to 0.
  - mcause 0x342.
  - mtval 0x343.
- Accept: req_valid & req_ready at posedge latches cause, tval, pc and rs1. Next state is chosen by cause:
  - CSR_W/S/C with a mapped address → CSR_RD.
  - CSR op with an unmapped address → TRAP; mcause=2 (illegal instruction), mtval=zero-extended e_tval[11:0].
  - ECALL → TRAP; mcause=11, mtval=0.
  - EBREAK → TRAP; mcause=3, mtval=pc.
  - RET → RET.
  - Cause 0 → RESP with no side effects, redirect=0, rd_data=0.
  - Any other code → TRAP as illegal instruction; mcause=2, mtval=0.
- CSR_RD (1 cycle): latch old = CSR value → CSR_WR.
- CSR_WR (1 cycle): write new value, then go to RESP with rd_data=old.
  - CSR_W: new = rs1.
  - CSR_S: new = old | rs1.
  - CSR_C: new = old & ~rs1.
  - The write always occurs, even when rs1=0.
- TRAP (1 cycle), then RESP with redirect=1 and redirect_pc={mtvec[63:2],2'b00}. Writes:
  - mepc = pc & ~3.
  - mcause and mtval as selected at accept.
  - MPIE = MIE, then MIE = 0.
- RET (1 cycle), then RESP with redirect=1 and redirect_pc=mepc. Writes: MIE = MPIE, MPIE = 1.
- RESP:
  - resp_valid=1; rd_data, redirect and redirect_pc are held stable until resp_ready.
  - On resp_valid & resp_ready → IDLE; outputs return to 0.
  - The next request can be accepted no earlier than the cycle after the response handshake.
- Latency: accept to resp_valid.
  - CSR op: 3 cycles.
  - Trap, RET: 2 cycles.
  - No-op: 1 cycle.
- Flush:
  - In CSR_RD, TRAP or RET → IDLE with no CSR write.
  - In CSR_WR, the write commits and the response is dropped → IDLE.
  - In RESP, the response is dropped → IDLE.
  - In IDLE, flush blocks accept that cycle.
  - Reset has priority over flush.
- When one CSR write targets mstatus, only the masked bits change.

Test Plan:
- Reset then idle: rst_n low 2 cycles → req_ready=1, resp_valid=0, mtvec read returns 64'h8000_0000.
- CSR_W then CSR_S on mscratch (0x340):
  - First request, rs1=0xA5 → rd_data=0, 3-cycle latency.
  - Second request, rs1=0x5A → rd_data=0xA5.
  - Read-back → 0xFF.
- ECALL at pc=0x8000_1004 with MIE=1 → redirect=1, redirect_pc=mtvec, mepc=0x8000_1004, mcause=11, mstatus=0x80.
- RET after the ECALL → redirect_pc=0x8000_1004, mstatus=0x88.
- CSR_C on unmapped 0x7C0 → mcause=2, mtval=0x7C0, redirect=1; no CSR content changes except the trap CSRs.
- Backpressure and flush:
  - Hold resp_ready=0 for 5 cycles → outputs stable and req_ready=0.
  - Separately, flush in CSR_RD → no write, IDLE next cycle.
